// File: rtl/bram_arb_pkg.sv
// Shared types and defaults for the two-master BRAM arbiter.
package bram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin winner select: a lone requester wins, a tie goes to the
// master that was not served last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       any,
  output logic       winner
);

  always_comb begin
    any = |req;
    if (&req) winner = ~last_grant;
    else      winner = req[1];
  end

endmodule

// File: rtl/bram_arbiter_2m.sv
// Shares one valid-ready BRAM slave between two masters, one access in flight,
// registered slave side, watchdog that completes hung accesses with an error.
//   state | meaning
//   IDLE  | no access; pick a winner from the pending requests
//   REQ   | s_valid held, waiting for s_ready or watchdog expiry
//   RESP  | ready pulse visible to the winner; no new grant
module bram_arbiter_2m
  import bram_arb_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [ADDR_W-1:0] s_addr,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wstrb,
  input  logic [31:0]       s_rdata
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t            state, state_nx;
  logic              last_grant, last_grant_nx;
  logic              grant, grant_nx;
  logic [CNT_W-1:0]  wd_cnt, wd_cnt_nx;
  logic              s_valid_nx;
  logic [ADDR_W-1:0] s_addr_nx;
  logic [31:0]       s_wdata_nx;
  logic [3:0]        s_wstrb_nx;
  logic              m0_ready_nx, m1_ready_nx, m0_err_nx, m1_err_nx;
  logic [31:0]       m0_rdata_nx, m1_rdata_nx;
  logic [31:0]       rsp_data;
  logic              rsp_err;
  logic              pick_any, pick_win;
  logic              wd_fire;

  rr_pick2 u_pick (
    .req        ({m1_valid, m0_valid}),
    .last_grant (last_grant),
    .any        (pick_any),
    .winner     (pick_win)
  );

  assign wd_fire = (TIMEOUT != 0) && (wd_cnt == CNT_W'(TIMEOUT));

  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    grant_nx      = grant;
    wd_cnt_nx     = wd_cnt;
    s_valid_nx    = s_valid;
    s_addr_nx     = s_addr;
    s_wdata_nx    = s_wdata;
    s_wstrb_nx    = s_wstrb;
    m0_ready_nx   = 1'b0;
    m1_ready_nx   = 1'b0;
    m0_rdata_nx   = '0;
    m1_rdata_nx   = '0;
    m0_err_nx     = 1'b0;
    m1_err_nx     = 1'b0;
    rsp_data      = s_ready ? s_rdata : ERR_RDATA;
    rsp_err       = ~s_ready;
    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_nx   = pick_win;
          s_valid_nx = 1'b1;
          s_addr_nx  = pick_win ? m1_addr  : m0_addr;
          s_wdata_nx = pick_win ? m1_wdata : m0_wdata;
          s_wstrb_nx = pick_win ? m1_wstrb : m0_wstrb;
          wd_cnt_nx  = '0;
          state_nx   = REQ;
        end
      end
      REQ: begin
        if (wd_cnt != '1) wd_cnt_nx = wd_cnt + CNT_W'(1);
        // A real s_ready wins over a watchdog expiry in the same cycle.
        if (s_ready || wd_fire) begin
          if (grant) begin
            m1_ready_nx = 1'b1;
            m1_rdata_nx = rsp_data;
            m1_err_nx   = rsp_err;
          end else begin
            m0_ready_nx = 1'b1;
            m0_rdata_nx = rsp_data;
            m0_err_nx   = rsp_err;
          end
          s_valid_nx    = 1'b0;
          last_grant_nx = grant;
          state_nx      = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      wd_cnt     <= '0;
      s_valid    <= 1'b0;
      s_addr     <= '0;
      s_wdata    <= '0;
      s_wstrb    <= '0;
      m0_ready   <= 1'b0;
      m1_ready   <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      grant      <= grant_nx;
      wd_cnt     <= wd_cnt_nx;
      s_valid    <= s_valid_nx;
      s_addr     <= s_addr_nx;
      s_wdata    <= s_wdata_nx;
      s_wstrb    <= s_wstrb_nx;
      m0_ready   <= m0_ready_nx;
      m1_ready   <= m1_ready_nx;
      m0_rdata   <= m0_rdata_nx;
      m1_rdata   <= m1_rdata_nx;
      m0_err     <= m0_err_nx;
      m1_err     <= m1_err_nx;
    end
  end

endmodule

// File: tb/tb_bram_arbiter_2m.sv
// Bench for bram_arbiter_2m: transaction-level reference model, memory-backed
// slave with per-access latency, directed cases followed by random traffic.
module tb_bram_arbiter_2m;

  localparam int TMO = 8;

  logic        clk, rst_n;
  logic        mv [2];
  logic        mr [2];
  logic [31:0] ma [2];
  logic [31:0] mw [2];
  logic [3:0]  ms [2];
  logic [31:0] mrd [2];
  logic        me [2];
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;

  bram_arbiter_2m #(.ADDR_W(32), .TIMEOUT(TMO), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(mv[0]), .m0_ready(mr[0]), .m0_addr(ma[0]), .m0_wdata(mw[0]),
    .m0_wstrb(ms[0]), .m0_rdata(mrd[0]), .m0_err(me[0]),
    .m1_valid(mv[1]), .m1_ready(mr[1]), .m1_addr(ma[1]), .m1_wdata(mw[1]),
    .m1_wstrb(ms[1]), .m1_rdata(mrd[1]), .m1_err(me[1]),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // slave memory, doubles as the reference memory
  logic [31:0] mem [int unsigned];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0] ^ 16'h3C3C, ~a[15:0]};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a >> 2)) return mem[a >> 2];
    return init_val(a);
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = mem_rd(a);
    for (int b = 0; b < 4; b++) if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
    mem[a >> 2] = v;
  endtask

  // transaction model state
  bit          active, cur_m, last_served, prev_sv, done_prev, exp_err;
  logic [31:0] cur_addr, cur_wdata, exp_rdata, last_rdata;
  logic [3:0]  cur_wstrb;
  bit          last_err, last_m;
  int          age, exp_k, lat, lat_fixed, slv_cnt, served;
  bit          hold [2];
  bit          drop_next [2];
  bit          grants [$];

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 9);
    if (r == 9) return 20;
    if (r == 8) return TMO;
    return $urandom_range(0, 3);
  endfunction

  task automatic tick();
    bit was_active, newt, expect_new, win, rdy_seen;
    @(negedge clk);
    newt       = s_valid && !prev_sv;
    rdy_seen   = 1'b0;
    was_active = active;
    if (was_active) begin
      age++;
      if (mr[0] || mr[1]) begin
        chk("ready_who", {mr[1], mr[0]}, cur_m ? 2'b10 : 2'b01);
        chk("ready_lat", age, exp_k);
        chk("rdata", mrd[cur_m], exp_rdata);
        chk("err", me[cur_m], exp_err);
        chk("s_valid_resp", s_valid, 1'b0);
        last_rdata  = mrd[cur_m];
        last_err    = me[cur_m];
        last_m      = cur_m;
        last_served = cur_m;
        active      = 1'b0;
        rdy_seen    = 1'b1;
        served++;
      end else if (age >= exp_k) begin
        chk("ready_missing", age, exp_k + 1);
        active = 1'b0;
      end else begin
        chk("s_hold", {s_valid, s_addr, s_wdata, s_wstrb}, {1'b1, cur_addr, cur_wdata, cur_wstrb});
      end
    end else begin
      if (mr[0] || mr[1]) chk("spurious_ready", {mr[1], mr[0]}, 2'b00);
      expect_new = (mv[0] || mv[1]) && !done_prev;
      chk("grant_timing", newt, expect_new);
      if (newt) begin
        win       = (mv[0] && mv[1]) ? ~last_served : mv[1];
        cur_m     = win;
        cur_addr  = ma[win];
        cur_wdata = mw[win];
        cur_wstrb = ms[win];
        chk("s_req", {s_addr, s_wdata, s_wstrb}, {cur_addr, cur_wdata, cur_wstrb});
        lat       = (lat_fixed >= 0) ? lat_fixed : pick_lat();
        exp_err   = (lat > TMO);
        exp_k     = exp_err ? TMO + 1 : lat + 1;
        exp_rdata = exp_err ? 32'hDEAD_BEEF : mem_rd(cur_addr);
        active    = 1'b1;
        age       = 0;
        slv_cnt   = 0;
        grants.push_back(win);
      end
    end
    for (int m = 0; m < 2; m++)
      if (!mr[m]) chk("quiet", {mrd[m], me[m]}, 33'h0);
    // slave: answer after lat cycles of s_valid, garbage data otherwise
    s_ready = 1'b0;
    s_rdata = $urandom;
    if (s_valid && active) begin
      if (slv_cnt == lat) begin
        s_ready = 1'b1;
        s_rdata = mem_rd(s_addr);
        mem_wr(s_addr, s_wdata, s_wstrb);
      end
      slv_cnt++;
    end
    for (int m = 0; m < 2; m++) begin
      if (drop_next[m]) begin mv[m] = 1'b0; drop_next[m] = 1'b0; end
      if (rdy_seen && int'(cur_m) == m) begin
        if (hold[m]) begin hold[m] = 1'b0; drop_next[m] = 1'b1; end
        else mv[m] = 1'b0;
      end
    end
    done_prev = rdy_seen;
    prev_sv   = s_valid;
  endtask

  task automatic issue(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mv[m] = 1'b1; ma[m] = a; mw[m] = d; ms[m] = s;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((active || mv[0] || mv[1]) && n < 300) begin tick(); n++; end
    chk("idle_reached", {active, mv[0], mv[1]}, 3'b000);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mv[0] = 1'b0; mv[1] = 1'b0; s_ready = 1'b0;
    @(negedge clk);
    chk("rst_slave", {s_valid, s_addr, s_wdata, s_wstrb}, 69'h0);
    chk("rst_master", {mr[0], mr[1], mrd[0], mrd[1], me[0], me[1]}, 68'h0);
    rst_n = 1'b1;
    active = 1'b0; last_served = 1'b1; prev_sv = 1'b0; done_prev = 1'b0;
    for (int m = 0; m < 2; m++) begin hold[m] = 1'b0; drop_next[m] = 1'b0; end
  endtask

  initial begin
    int iss [2];
    int n, s0;
    logic [31:0] tmp;
    for (int m = 0; m < 2; m++) begin
      mv[m] = 1'b0; ma[m] = '0; mw[m] = '0; ms[m] = '0;
    end
    s_ready = 1'b0; s_rdata = '0; served = 0; lat_fixed = 0;
    do_reset();

    // lone m0 read, 2-cycle slave
    mem[32'h10 >> 2] = 32'h1234_5678;
    lat_fixed = 2;
    tick();
    issue(0, 32'h10, 32'h0, 4'b0000);
    wait_idle();
    chk("t1_rdata", last_rdata, 32'h1234_5678);
    chk("t1_err_m", {last_err, last_m}, 2'b00);

    // simultaneous requests alternate starting with m0
    do_reset();
    grants.delete();
    lat_fixed = 1;
    for (int r = 0; r < 4; r++) begin
      issue(0, 32'h100 + 32'(r * 4), $urandom, 4'b0000);
      issue(1, 32'h200 + 32'(r * 4), $urandom, 4'b0000);
      wait_idle();
    end
    chk("t2_count", grants.size(), 8);
    for (int i = 0; i < grants.size(); i++) chk("t2_order", grants[i], i[0]);

    // m1 partial write then m0 readback
    lat_fixed = 3;
    issue(1, 32'h4004, 32'hA5A5_A5A5, 4'b0011);
    wait_idle();
    issue(0, 32'h4004, 32'h0, 4'b0000);
    wait_idle();
    tmp = init_val(32'h4004);
    chk("t3_low", last_rdata[15:0], 16'hA5A5);
    chk("t3_high", last_rdata[31:16], tmp[31:16]);

    // watchdog completion
    lat_fixed = 100;
    issue(0, 32'h20, 32'h0, 4'b0000);
    wait_idle();
    chk("t4_err", {last_err, last_rdata}, {1'b1, 32'hDEAD_BEEF});
    chk("t4_sv_after", s_valid, 1'b0);

    // reset in REQ, then normal service
    issue(0, 32'h30, 32'h0, 4'b0000);
    for (int i = 0; i < 3; i++) tick();
    chk("t5_busy", s_valid, 1'b1);
    do_reset();
    lat_fixed = 0;
    issue(1, 32'h34, 32'h0, 4'b0000);
    wait_idle();
    chk("t5_after", {last_m, last_err}, 2'b10);

    // m0 keeps valid one cycle past its ready pulse
    lat_fixed = 2;
    hold[0] = 1'b1;
    s0 = served;
    issue(0, 32'h8, 32'h0, 4'b0000);
    n = 0;
    while (served == s0 && n < 50) begin tick(); n++; end
    chk("t6_served", served, s0 + 1);
    tick();
    chk("t6_no_reissue", s_valid, 1'b0);
    tick();
    chk("t6_still_idle", s_valid, 1'b0);
    wait_idle();

    // random traffic from both masters
    lat_fixed = -1;
    s0 = served;
    iss[0] = 0; iss[1] = 0;
    n = 0;
    while ((iss[0] < 60 || iss[1] < 60) && n < 4000) begin
      tick();
      n++;
      for (int m = 0; m < 2; m++) begin
        if (!mv[m] && !drop_next[m] && iss[m] < 60 && $urandom_range(0, 2) == 0) begin
          hold[m] = ($urandom_range(0, 3) == 0);
          issue(m, 32'($urandom_range(0, 15)) << 2, $urandom,
                ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000);
          iss[m]++;
        end
      end
    end
    wait_idle();
    chk("rand_served", served - s0, iss[0] + iss[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
